// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline memory port between the I-cache and the D-cache.
// Requests are arbitrated in IDLE only; a tie goes to the side that was not
// granted last. The winning request is captured in a latch that alone drives
// the memory port. The memory response is routed back combinationally, and
// only to the owner of the transaction.

module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  // Encoding of the last granted side.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                i_req_s;
  logic                d_req_s;

  assign i_req_s = i_read;
  assign d_req_s = d_read | d_write;

  // The memory port is driven from the request latch only.
  assign pmem_read  = read_q;
  assign pmem_write = write_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  // Next-state, grant decision, latch loading and response routing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;

    case (state_q)
      IDLE: begin
        // I wins when it is alone, or on a tie when D was granted last.
        if (i_req_s && (!d_req_s || (last_grant_q == GRANT_D))) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          read_d       = 1'b1;
          write_d      = 1'b0;
          addr_d       = i_addr;
        end else if (d_req_s) begin
          // A simultaneous D read and write is illegal; the write wins.
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          read_d       = ~d_write;
          write_d      = d_write;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
        end else begin
          state_d = IDLE;
        end
      end

      SERVE_I: begin
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          state_d = SERVE_I;
        end
      end

      SERVE_D: begin
        if (pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = pmem_rdata;
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          state_d = SERVE_D;
        end
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State, grant history and request latch; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  cache_mem_arbiter_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .d_read     (d_read),
    .d_write    (d_write),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write)
  );

endmodule

// Simulation-only protocol checks for the arbiter.
module cache_mem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic d_read,
  input logic d_write,
  input logic pmem_read,
  input logic pmem_write
);

  // Flag illegal D requests and conflicting memory strobes at each edge.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
      else $warning("cache_mem_arbiter: d_read and d_write asserted together, performing write");
      assert (!(pmem_read && pmem_write))
      else $error("cache_mem_arbiter: pmem_read and pmem_write high together");
    end else begin
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. Inputs are driven 1 time unit after
// each rising edge, outputs are checked 1 time unit after that.

module tb_cache_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int pass_cnt;
  int total_cnt;

  localparam logic [LINE_W-1:0] LINE_AA = {32{8'hAA}};
  localparam logic [LINE_W-1:0] LINE_55 = {32{8'h55}};
  localparam logic [LINE_W-1:0] LINE_C3 = {32{8'hC3}};
  localparam logic [LINE_W-1:0] LINE_WR = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] LINE_GB = {8{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] LINE_IL = {8{32'h0BAD_F00D}};

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the inputs set in this cycle settle before checking.
  task automatic settle();
    #1;
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // ---------------- reset state
    tick();
    tick();
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_addr", pmem_addr, 32'h0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_i_resp", i_resp, 1'b0);
    check("rst_d_resp", d_resp, 1'b0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst = 1'b0;

    // ---------------- I-only read, memory answers 4 cycles after strobe
    i_read = 1'b1;
    i_addr = 32'h0000_0060;
    tick();                                   // cycle 1
    check("i1_c1_read", pmem_read, 1'b1);
    check("i1_c1_write", pmem_write, 1'b0);
    check("i1_c1_addr", pmem_addr, 32'h60);
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    tick();                                   // cycle 4
    settle();
    check("i1_c4_read", pmem_read, 1'b1);
    check("i1_c4_iresp", i_resp, 1'b0);
    tick();                                   // cycle 5: response
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_AA;
    i_read     = 1'b0;
    settle();
    check("i1_c5_read", pmem_read, 1'b1);
    check("i1_c5_addr", pmem_addr, 32'h60);
    check("i1_c5_iresp", i_resp, 1'b1);
    check("i1_c5_irdata", i_rdata, LINE_AA);
    check("i1_c5_dresp", d_resp, 1'b0);
    check("i1_c5_drdata", d_rdata, '0);
    tick();                                   // cycle 6
    pmem_resp  = 1'b0;
    settle();
    check("i1_c6_read", pmem_read, 1'b0);
    check("i1_c6_iresp", i_resp, 1'b0);
    check("i1_c6_irdata", i_rdata, '0);

    // ---------------- tie: D first, then I, then D again on the next tie
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    i_read  = 1'b1;
    i_addr  = 32'h100;
    d_read  = 1'b1;
    d_addr  = 32'h200;
    tick();
    check("tie_d_read", pmem_read, 1'b1);
    check("tie_d_addr", pmem_addr, 32'h200);
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_55;
    d_read     = 1'b0;
    settle();
    check("tie_d_dresp", d_resp, 1'b1);
    check("tie_d_drdata", d_rdata, LINE_55);
    check("tie_d_iresp", i_resp, 1'b0);
    check("tie_d_irdata", i_rdata, '0);
    tick();                                   // mandatory IDLE cycle
    pmem_resp = 1'b0;
    settle();
    check("tie_idle_read", pmem_read, 1'b0);
    tick();
    check("tie_i_read", pmem_read, 1'b1);
    check("tie_i_addr", pmem_addr, 32'h100);
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_C3;
    i_read     = 1'b0;
    settle();
    check("tie_i_iresp", i_resp, 1'b1);
    check("tie_i_irdata", i_rdata, LINE_C3);
    check("tie_i_dresp", d_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b1;
    d_read    = 1'b1;
    tick();
    check("tie2_addr", pmem_addr, 32'h200);
    check("tie2_read", pmem_read, 1'b1);
    pmem_resp = 1'b1;
    d_read    = 1'b0;
    settle();
    check("tie2_dresp", d_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    tick();
    check("tie2_i_addr", pmem_addr, 32'h100);
    pmem_resp = 1'b1;
    i_read    = 1'b0;
    settle();
    check("tie2_iresp", i_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;

    // ---------------- D writeback, requester inputs change after grant
    d_write = 1'b1;
    d_addr  = 32'h400;
    d_wdata = LINE_WR;
    tick();
    check("wb_c1_write", pmem_write, 1'b1);
    check("wb_c1_read", pmem_read, 1'b0);
    check("wb_c1_addr", pmem_addr, 32'h400);
    check("wb_c1_wdata", pmem_wdata, LINE_WR);
    d_addr  = 32'hDEAD_BEEF;
    d_wdata = LINE_GB;
    i_addr  = 32'hFFFF_FFC0;
    tick();
    check("wb_c2_write", pmem_write, 1'b1);
    check("wb_c2_addr", pmem_addr, 32'h400);
    check("wb_c2_wdata", pmem_wdata, LINE_WR);
    tick();
    pmem_resp = 1'b1;
    d_write   = 1'b0;
    settle();
    check("wb_c3_write", pmem_write, 1'b1);
    check("wb_c3_wdata", pmem_wdata, LINE_WR);
    check("wb_c3_dresp", d_resp, 1'b1);
    check("wb_c3_iresp", i_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    settle();
    check("wb_c4_write", pmem_write, 1'b0);
    check("wb_c4_dresp", d_resp, 1'b0);

    // ---------------- reset two cycles into SERVE_I
    i_read = 1'b1;
    i_addr = 32'h80;
    tick();
    check("rm_c1_read", pmem_read, 1'b1);
    check("rm_c1_addr", pmem_addr, 32'h80);
    tick();
    rst    = 1'b1;
    i_read = 1'b0;
    tick();
    check("rm_after_read", pmem_read, 1'b0);
    check("rm_after_addr", pmem_addr, 32'h0);
    rst = 1'b0;
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_AA;
    settle();
    check("rm_late_iresp", i_resp, 1'b0);
    check("rm_late_dresp", d_resp, 1'b0);
    check("rm_late_irdata", i_rdata, '0);
    tick();
    pmem_resp = 1'b0;
    settle();
    check("rm_late_read", pmem_read, 1'b0);

    // ---------------- spurious pmem_resp in IDLE
    pmem_resp = 1'b1;
    settle();
    check("sp_iresp", i_resp, 1'b0);
    check("sp_dresp", d_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    settle();
    check("sp_read", pmem_read, 1'b0);
    check("sp_write", pmem_write, 1'b0);

    // ---------------- illegal D read+write: the write is performed
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h500;
    d_wdata = LINE_IL;
    tick();
    check("il_write", pmem_write, 1'b1);
    check("il_read", pmem_read, 1'b0);
    check("il_addr", pmem_addr, 32'h500);
    check("il_wdata", pmem_wdata, LINE_IL);
    pmem_resp = 1'b1;
    d_read    = 1'b0;
    d_write   = 1'b0;
    settle();
    check("il_dresp", d_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    settle();
    check("il_done_write", pmem_write, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
